stage_ex_md: RTL and testbench

Parametrised execute stage with an integrated iterative multiply/divide unit (RV32M-class) and registered EX/MEM outputs. Single-cycle logic, shift and arithmetic classes retire one cycle after acceptance. MUL/DIV/REM ops occupy the unit for XLEN+1 cycles behind a valid/ready handshake. It sits between decode (upstream, valid_i/ready_o) and memory (downstream, valid_o/stall_i), and it replaces the purely combinational execute stage.

---
 rtl/ex_pkg.sv | 26 ++
 rtl/ex_muldiv_iter.sv | 80 ++++++++
 rtl/stage_ex_md.sv | 105 ++++++++++
 tb/tb_stage_ex_md.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_pkg.sv
// ex_pkg: class/op encodings and iteration FSM states for the execute stage
package ex_pkg;
  localparam logic [2:0] ALUSEL_LOGIC  = 3'b001;
  localparam logic [2:0] ALUSEL_SHIFT  = 3'b010;
  localparam logic [2:0] ALUSEL_ARITH  = 3'b100;
  localparam logic [2:0] ALUSEL_MULDIV = 3'b101;
  localparam logic [2:0] ALUOP_OR      = 3'd0;
  localparam logic [2:0] ALUOP_AND     = 3'd1;
  localparam logic [2:0] ALUOP_XOR     = 3'd2;
  localparam logic [2:0] ALUOP_SLL     = 3'd0;
  localparam logic [2:0] ALUOP_SRL     = 3'd1;
  localparam logic [2:0] ALUOP_SRA     = 3'd2;
  localparam logic [2:0] ALUOP_ADD     = 3'd0;
  localparam logic [2:0] ALUOP_SUB     = 3'd1;
  localparam logic [2:0] ALUOP_SLT     = 3'd2;
  localparam logic [2:0] ALUOP_SLTU    = 3'd3;
  localparam logic [2:0] ALUOP_MUL     = 3'd0;
  localparam logic [2:0] ALUOP_MULH    = 3'd1;
  localparam logic [2:0] ALUOP_MULHSU  = 3'd2;
  localparam logic [2:0] ALUOP_MULHU   = 3'd3;
  localparam logic [2:0] ALUOP_DIV     = 3'd4;
  localparam logic [2:0] ALUOP_DIVU    = 3'd5;
  localparam logic [2:0] ALUOP_REM     = 3'd6;
  localparam logic [2:0] ALUOP_REMU    = 3'd7;
  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;
endpackage

// File: rtl/ex_muldiv_iter.sv
// ex_muldiv_iter: radix-2 shift-add multiplier / restoring divider on magnitudes with sign fix-up
module ex_muldiv_iter
  import ex_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            start,
  input  logic            hold,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            idle,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN);
  state_t state;
  logic [CW-1:0] cnt;
  logic [XLEN-1:0] acc, mq, den, acc_nx, mq_nx, quo, rem, mag_a, mag_b;
  logic [2:0] op_q;
  logic neg_q, neg_r, a_neg, b_neg;
  logic [XLEN:0] add_sum, sub_diff;
  logic [2*XLEN-1:0] prod;
  assign a_neg = a[XLEN-1] && (op == ALUOP_MULH || op == ALUOP_MULHSU || op == ALUOP_DIV || op == ALUOP_REM);
  assign b_neg = b[XLEN-1] && (op == ALUOP_MULH || op == ALUOP_DIV || op == ALUOP_REM);
  assign mag_a = a_neg ? -a : a;
  assign mag_b = b_neg ? -b : b;
  assign add_sum = {1'b0, acc} + (mq[0] ? {1'b0, den} : '0);
  assign sub_diff = {acc, mq[XLEN-1]} - {1'b0, den};
  assign acc_nx = state == MUL ? add_sum[XLEN:1]
                : sub_diff[XLEN] ? {acc[XLEN-2:0], mq[XLEN-1]} : sub_diff[XLEN-1:0];
  assign mq_nx = state == MUL ? {add_sum[0], mq[XLEN-1:1]} : {mq[XLEN-2:0], ~sub_diff[XLEN]};
  assign prod = neg_q ? -{acc, mq} : {acc, mq};
  assign quo = neg_q ? -mq : mq;
  assign rem = neg_r ? -acc : acc;
  assign result = op_q == ALUOP_MUL ? prod[XLEN-1:0]
                : (op_q == ALUOP_DIV || op_q == ALUOP_DIVU) ? quo
                : (op_q == ALUOP_REM || op_q == ALUOP_REMU) ? rem
                : prod[2*XLEN-1:XLEN];
  assign idle = state == IDLE;
  assign done = state == FIX;
  // load magnitudes on start, one radix-2 step per cycle, wait in FIX until the output is free
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      acc   <= '0;
      mq    <= '0;
      den   <= '0;
      op_q  <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (start) begin
          acc   <= '0;
          mq    <= mag_a;
          den   <= mag_b;
          op_q  <= op;
          neg_q <= a_neg ^ b_neg;
          neg_r <= a_neg;
          cnt   <= CW'(XLEN - 1);
          state <= op >= ALUOP_DIV ? DIV : MUL;
        end
        MUL, DIV: begin
          acc <= acc_nx;
          mq  <= mq_nx;
          cnt <= cnt - CW'(1);
          if (cnt == '0) state <= FIX;
        end
        default: if (!hold) state <= IDLE;
      endcase
    end
  end
endmodule

// File: rtl/stage_ex_md.sv
// stage_ex_md: execute stage with single-cycle ALU, iterative mul/div and registered EX/MEM outputs
module stage_ex_md
  import ex_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int REGADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [2:0]           alusel,
  input  logic [2:0]           aluop,
  input  logic [XLEN-1:0]      op1,
  input  logic [XLEN-1:0]      op2,
  input  logic                 write_i,
  input  logic [REGADDR_W-1:0] regw_addr_i,
  input  logic                 flush_i,
  input  logic                 stall_i,
  output logic                 valid_o,
  output logic                 write_o,
  output logic [REGADDR_W-1:0] regw_addr_o,
  output logic [XLEN-1:0]      regw_data
);
  localparam int SW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  logic [SW-1:0] sh;
  logic slt, sltu, hold, accept, is_md, fast, start, rem_op, md_idle, md_done, md_write;
  logic [REGADDR_W-1:0] md_addr;
  logic [XLEN-1:0] sra_res, logic_res, shift_res, arith_res, fast_res, alu_res, md_res;
  assign sh = op2[SW-1:0];
  assign sra_res = $signed(op1) >>> sh;
  assign slt = $signed(op1) < $signed(op2);
  assign sltu = op1 < op2;
  assign logic_res = aluop == ALUOP_OR ? op1 | op2
                   : aluop == ALUOP_AND ? op1 & op2
                   : aluop == ALUOP_XOR ? op1 ^ op2 : '0;
  assign shift_res = aluop == ALUOP_SLL ? op1 << sh
                   : aluop == ALUOP_SRL ? op1 >> sh
                   : aluop == ALUOP_SRA ? sra_res : '0;
  assign arith_res = aluop == ALUOP_ADD ? op1 + op2
                   : aluop == ALUOP_SUB ? op1 - op2
                   : aluop == ALUOP_SLT ? XLEN'(slt)
                   : aluop == ALUOP_SLTU ? XLEN'(sltu) : '0;
  assign rem_op = aluop == ALUOP_REM || aluop == ALUOP_REMU;
  assign fast = aluop >= ALUOP_DIV && (op2 == '0 ||
                ((aluop == ALUOP_DIV || aluop == ALUOP_REM) && op1 == MIN_NEG && op2 == '1));
  assign fast_res = op2 == '0 ? (rem_op ? op1 : '1) : (rem_op ? '0 : op1);
  assign alu_res = alusel == ALUSEL_LOGIC ? logic_res
                 : alusel == ALUSEL_SHIFT ? shift_res
                 : alusel == ALUSEL_ARITH ? arith_res
                 : alusel == ALUSEL_MULDIV ? fast_res : '0;
  assign hold = valid_o && stall_i;
  assign ready_o = md_idle && !hold;
  assign accept = valid_i && ready_o && !flush_i;
  assign is_md = alusel == ALUSEL_MULDIV;
  assign start = accept && is_md && !fast;
  ex_muldiv_iter #(.XLEN(XLEN)) u_md (
    .clk(clk),
    .reset(reset),
    .flush(flush_i),
    .start(start),
    .hold(hold),
    .op(aluop),
    .a(op1),
    .b(op2),
    .idle(md_idle),
    .done(md_done),
    .result(md_res)
  );
  // an iterating op keeps the destination it was accepted with
  always_ff @(posedge clk) begin
    if (!reset) begin
      md_write <= 1'b0;
      md_addr  <= '0;
    end else if (start) begin
      md_write <= write_i;
      md_addr  <= regw_addr_i;
    end
  end
  // EX/MEM output registers: flush clears, new results load, stall holds, else drain
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_o     <= 1'b0;
      write_o     <= 1'b0;
      regw_addr_o <= '0;
      regw_data   <= '0;
    end else if (flush_i) begin
      valid_o <= 1'b0;
      write_o <= 1'b0;
    end else if (accept && !start) begin
      valid_o     <= 1'b1;
      write_o     <= write_i;
      regw_addr_o <= regw_addr_i;
      regw_data   <= alu_res;
    end else if (md_done && !hold) begin
      valid_o     <= 1'b1;
      write_o     <= md_write;
      regw_addr_o <= md_addr;
      regw_data   <= md_res;
    end else if (!stall_i) begin
      valid_o <= 1'b0;
    end
  end
endmodule

// File: tb/tb_stage_ex_md.sv
// tb_stage_ex_md: directed self-checking bench for stage_ex_md
module tb_stage_ex_md;
  import ex_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic valid_i = 1'b0;
  logic ready_o;
  logic [2:0] alusel = '0;
  logic [2:0] aluop = '0;
  logic [31:0] op1 = '0;
  logic [31:0] op2 = '0;
  logic write_i = 1'b0;
  logic [4:0] regw_addr_i = '0;
  logic flush_i = 1'b0;
  logic stall_i = 1'b0;
  logic valid_o, write_o;
  logic [4:0] regw_addr_o;
  logic [31:0] regw_data;
  int n_cmp = 0;
  int n_fail = 0;
  stage_ex_md #(.XLEN(32), .REGADDR_W(5)) dut (
    .clk(clk),
    .reset(reset),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .alusel(alusel),
    .aluop(aluop),
    .op1(op1),
    .op2(op2),
    .write_i(write_i),
    .regw_addr_i(regw_addr_i),
    .flush_i(flush_i),
    .stall_i(stall_i),
    .valid_o(valid_o),
    .write_o(write_o),
    .regw_addr_o(regw_addr_o),
    .regw_data(regw_data)
  );
  always #5 clk = ~clk;
  task automatic drive(input logic [2:0] sel, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] addr, input logic wr);
    alusel = sel;
    aluop = op;
    op1 = a;
    op2 = b;
    regw_addr_i = addr;
    write_i = wr;
    valid_i = 1'b1;
  endtask
  task automatic test_reset;
    reset = 1'b0;
    stall_i = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid_o); end
    n_cmp++;
    if (regw_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", regw_data); end
    n_cmp++;
    if (ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", ready_o); end
    n_cmp++;
    if ({write_o, regw_addr_o} !== 6'h0) begin n_fail++; $display("FAIL reset_wr_addr: got %b/%0d want 0/0", write_o, regw_addr_o); end
  endtask
  task automatic test_add;
    drive(ALUSEL_ARITH, ALUOP_ADD, 32'd7, 32'hFFFF_FFFD, 5'd5, 1'b1);
    @(negedge clk);
    valid_i = 1'b0;
    n_cmp++;
    if ({valid_o, write_o, regw_addr_o, regw_data} !== {1'b1, 1'b1, 5'd5, 32'd4}) begin
      n_fail++;
      $display("FAIL add: got v=%b w=%b a=%0d d=%h want v=1 w=1 a=5 d=00000004", valid_o, write_o, regw_addr_o, regw_data);
    end
    @(negedge clk);
    n_cmp++;
    if (valid_o !== 1'b0) begin n_fail++; $display("FAIL add_drain: got %b want 0", valid_o); end
  endtask
  task automatic test_back_to_back;
    logic [2:0] sel [12] = '{ALUSEL_LOGIC, ALUSEL_LOGIC, ALUSEL_LOGIC, ALUSEL_SHIFT, ALUSEL_SHIFT, ALUSEL_SHIFT,
                             ALUSEL_ARITH, ALUSEL_ARITH, ALUSEL_ARITH, 3'b011, ALUSEL_LOGIC, ALUSEL_ARITH};
    logic [2:0] op [12] = '{ALUOP_OR, ALUOP_AND, ALUOP_XOR, ALUOP_SLL, ALUOP_SRL, ALUOP_SRA,
                            ALUOP_SUB, ALUOP_SLTU, ALUOP_SLT, 3'd0, 3'd5, ALUOP_SLT};
    logic [31:0] a [12] = '{32'hF0F0_0000, 32'hFF00_FF00, 32'hFFFF_0000, 32'h1, 32'h8000_0000, 32'h8000_0000,
                            32'd5, 32'd1, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] b [12] = '{32'h0000_0F0F, 32'h0FF0_0FF0, 32'h0F0F_0F0F, 32'h23, 32'h4, 32'h1F,
                            32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1};
    logic [31:0] e [12] = '{32'hF0F0_0F0F, 32'h0F00_0F00, 32'hF0F0_0F0F, 32'h8, 32'h0800_0000, 32'hFFFF_FFFF,
                            32'hFFFF_FFFE, 32'd1, 32'd0, 32'd0, 32'd0, 32'd1};
    logic w [12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 12; i++) begin
      drive(sel[i], op[i], a[i], b[i], 5'(i + 1), w[i]);
      @(negedge clk);
      n_cmp++;
      if ({valid_o, write_o, regw_addr_o, regw_data} !== {1'b1, w[i], 5'(i + 1), e[i]}) begin
        n_fail++;
        $display("FAIL b2b_%0d: got v=%b w=%b a=%0d d=%h want v=1 w=%b a=%0d d=%h",
                 i, valid_o, write_o, regw_addr_o, regw_data, w[i], i + 1, e[i]);
      end
    end
    valid_i = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_mulh_busy;
    bit early = 1'b0;
    bit busy_ok = 1'b1;
    drive(ALUSEL_MULDIV, ALUOP_MULH, 32'h8000_0000, 32'h8000_0000, 5'd7, 1'b1);
    @(negedge clk);
    drive(ALUSEL_ARITH, ALUOP_ADD, 32'd1, 32'd1, 5'd9, 1'b1);
    for (int k = 1; k <= 32; k++) begin
      if (ready_o !== 1'b0) busy_ok = 1'b0;
      @(negedge clk);
      if (valid_o !== 1'b0) early = 1'b1;
    end
    n_cmp++;
    if (!busy_ok) begin n_fail++; $display("FAIL mulh_ready_busy: got ready high want 0 while iterating"); end
    n_cmp++;
    if (early) begin n_fail++; $display("FAIL mulh_early: got valid_o before edge 33 want none"); end
    @(negedge clk);
    n_cmp++;
    if ({valid_o, regw_addr_o, regw_data} !== {1'b1, 5'd7, 32'h4000_0000}) begin
      n_fail++;
      $display("FAIL mulh_result: got v=%b a=%0d d=%h want v=1 a=7 d=40000000", valid_o, regw_addr_o, regw_data);
    end
    @(negedge clk);
    valid_i = 1'b0;
    n_cmp++;
    if ({valid_o, regw_addr_o, regw_data} !== {1'b1, 5'd9, 32'd2}) begin
      n_fail++;
      $display("FAIL mulh_next_add: got v=%b a=%0d d=%h want v=1 a=9 d=00000002", valid_o, regw_addr_o, regw_data);
    end
    @(negedge clk);
  endtask
  task automatic test_muldiv;
    logic [2:0] op [13] = '{ALUOP_DIV, ALUOP_REM, ALUOP_DIVU, ALUOP_REM, ALUOP_DIV, ALUOP_REM, ALUOP_MULHU,
                            ALUOP_MULHSU, ALUOP_REMU, ALUOP_MUL, ALUOP_DIVU, ALUOP_DIV, ALUOP_DIVU};
    logic [31:0] a [13] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'h1234_5678, 32'h1234_5678, 32'h8000_0000, 32'h8000_0000,
                            32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd100, 32'hFFFF_FFFD, 32'd100, 32'd5, 32'h8000_0000};
    logic [31:0] b [13] = '{32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                            32'hFFFF_FFFF, 32'd2, 32'd7, 32'd5, 32'd7, 32'd0, 32'hFFFF_FFFF};
    logic [31:0] e [13] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1234_5678, 32'h8000_0000, 32'd0,
                            32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFF1, 32'd14, 32'hFFFF_FFFF, 32'd0};
    int lat [13] = '{33, 33, 0, 0, 0, 0, 33, 33, 33, 33, 33, 0, 33};
    int n;
    for (int i = 0; i < 13; i++) begin
      drive(ALUSEL_MULDIV, op[i], a[i], b[i], 5'(i + 16), 1'b1);
      @(negedge clk);
      valid_i = 1'b0;
      n = 0;
      while (valid_o !== 1'b1 && n < 40) begin
        @(negedge clk);
        n++;
      end
      n_cmp++;
      if (n != lat[i]) begin n_fail++; $display("FAIL md_latency_%0d: got %0d want %0d", i, n, lat[i]); end
      n_cmp++;
      if ({valid_o, regw_addr_o, regw_data} !== {1'b1, 5'(i + 16), e[i]}) begin
        n_fail++;
        $display("FAIL md_result_%0d: got v=%b a=%0d d=%h want v=1 a=%0d d=%h", i, valid_o, regw_addr_o, regw_data, i + 16, e[i]);
      end
    end
    @(negedge clk);
  endtask
  task automatic test_flush;
    bit seen = 1'b0;
    drive(ALUSEL_MULDIV, ALUOP_DIVU, 32'd100, 32'd7, 5'd3, 1'b1);
    @(negedge clk);
    valid_i = 1'b0;
    repeat (9) @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    n_cmp++;
    if ({valid_o, write_o, ready_o} !== 3'b001) begin
      n_fail++;
      $display("FAIL flush_state: got v=%b w=%b r=%b want v=0 w=0 r=1", valid_o, write_o, ready_o);
    end
    drive(ALUSEL_ARITH, ALUOP_ADD, 32'd10, 32'd20, 5'd4, 1'b1);
    @(negedge clk);
    valid_i = 1'b0;
    n_cmp++;
    if ({valid_o, regw_addr_o, regw_data} !== {1'b1, 5'd4, 32'd30}) begin
      n_fail++;
      $display("FAIL flush_next_add: got v=%b a=%0d d=%h want v=1 a=4 d=0000001e", valid_o, regw_addr_o, regw_data);
    end
    repeat (35) begin
      @(negedge clk);
      if (valid_o !== 1'b0) seen = 1'b1;
    end
    n_cmp++;
    if (seen) begin n_fail++; $display("FAIL flush_ghost: got late valid_o want none"); end
  endtask
  task automatic test_reset_mid;
    bit seen = 1'b0;
    drive(ALUSEL_MULDIV, ALUOP_MUL, 32'd6, 32'd7, 5'd8, 1'b1);
    @(negedge clk);
    valid_i = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    n_cmp++;
    if ({valid_o, ready_o} !== 2'b01) begin n_fail++; $display("FAIL rstmid_state: got v=%b r=%b want v=0 r=1", valid_o, ready_o); end
    repeat (40) begin
      @(negedge clk);
      if (valid_o !== 1'b0) seen = 1'b1;
    end
    n_cmp++;
    if (seen) begin n_fail++; $display("FAIL rstmid_ghost: got late valid_o want none"); end
  endtask
  task automatic test_stall;
    int n = 0;
    drive(ALUSEL_MULDIV, ALUOP_MUL, 32'hFFFF_FFFD, 32'd5, 5'd12, 1'b1);
    @(negedge clk);
    valid_i = 1'b0;
    stall_i = 1'b1;
    while (valid_o !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if ({valid_o, regw_addr_o, regw_data} !== {1'b1, 5'd12, 32'hFFFF_FFF1} || n != 33) begin
      n_fail++;
      $display("FAIL stall_mul: got v=%b a=%0d d=%h n=%0d want v=1 a=12 d=fffffff1 n=33", valid_o, regw_addr_o, regw_data, n);
    end
    drive(ALUSEL_ARITH, ALUOP_ADD, 32'd2, 32'd3, 5'd13, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({valid_o, write_o, regw_addr_o, regw_data, ready_o} !== {1'b1, 1'b1, 5'd12, 32'hFFFF_FFF1, 1'b0}) begin
        n_fail++;
        $display("FAIL stall_hold_%0d: got v=%b w=%b a=%0d d=%h r=%b want v=1 w=1 a=12 d=fffffff1 r=0",
                 k, valid_o, write_o, regw_addr_o, regw_data, ready_o);
      end
    end
    stall_i = 1'b0;
    @(negedge clk);
    valid_i = 1'b0;
    n_cmp++;
    if ({valid_o, regw_addr_o, regw_data} !== {1'b1, 5'd13, 32'd5}) begin
      n_fail++;
      $display("FAIL stall_release: got v=%b a=%0d d=%h want v=1 a=13 d=00000005", valid_o, regw_addr_o, regw_data);
    end
    @(negedge clk);
  endtask
  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_mulh_busy();
    test_muldiv();
    test_flush();
    test_reset_mid();
    test_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
